dac_pulse_driver: RTL



---
 rtl/dac_pulse_pkg.sv | 38 +++
 rtl/dac_pulse_driver_gpio_write_decoder.sv | 39 +++
 rtl/dac_pulse_driver.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/dac_pulse_pkg.sv
// dac_pulse_pkg: shared widths, GPIO field offsets and FSM encodings
// for the DAC pulse driver and its GPIO write decoder.
package dac_pulse_pkg;

  localparam int LANES    = 8;
  localparam int SAMPLE_W = 16;
  localparam int VAL_W    = 8;

  localparam int ADDR_LSB = 0;
  localparam int DATA_LSB = 16;
  localparam int WCLK_BIT = 24;

  typedef enum logic [0:0] {
    S_HI = 1'b0,
    S_LO = 1'b1
  } byte_st_e;

  typedef enum logic [0:0] {
    ST_RESET  = 1'b0,
    ST_STREAM = 1'b1
  } out_st_e;

  // Fill every lane with the idle code, then drop the sample
  // into its lane when a pulse is present.
  function automatic logic [LANES*SAMPLE_W-1:0] build_word(
    input logic [SAMPLE_W-1:0] idle,
    input logic [SAMPLE_W-1:0] code,
    input logic                pulse,
    input int                  lane
  );
    logic [LANES*SAMPLE_W-1:0] w;
    w = {LANES{idle}};
    if (pulse)
      w[lane*SAMPLE_W +: SAMPLE_W] = code;
    return w;
  endfunction

endpackage

// File: rtl/dac_pulse_driver_gpio_write_decoder.sv
// gpio_write_decoder: synchronizes the PS w_clk strobe and emits one
// wr_pulse per rising edge with the addr/data fields captured alongside.
// Ports: clk, rst, gpio_in[31:0] in; wr_pulse, wr_addr[15:0], wr_data[7:0] out.
module gpio_write_decoder
  import dac_pulse_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] gpio_in,
  output logic        wr_pulse,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data
);

  // sync[1:0] is the 2-flop synchronizer, sync[2] the edge history
  logic [2:0] sync;
  logic       rise;
  logic       unused_gpio;

  assign rise        = sync[1] & ~sync[2];
  assign unused_gpio = ^gpio_in[31:25];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync     <= '0;
      wr_pulse <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      sync     <= {sync[1:0], gpio_in[WCLK_BIT]};
      wr_pulse <= rise;
      if (rise) begin
        wr_addr <= gpio_in[ADDR_LSB +: 16];
        wr_data <= gpio_in[DATA_LSB +: 8];
      end
    end
  end

endmodule

// File: rtl/dac_pulse_driver.sv
// dac_pulse_driver: 8-bit FSM values -> GPIO-loaded 256x16 LUT -> 8-lane
// 128-bit AXI-Stream to the RF DAC. Optional macro DAC_IDLE_REG_EN adds a
// GPIO-writable idle code. Ports: clk, rst, gpio_in, val_in/valid/ready,
// dac_output_run, m_axis_tdata/tvalid/tready, fifo_overflow (sticky).
module dac_pulse_driver
  import dac_pulse_pkg::*;
#(
  parameter logic [15:0]         ADDR_PTR   = 16'd0,
  parameter logic [15:0]         ADDR_DATA  = 16'd1,
  parameter logic [15:0]         ADDR_IDLE  = 16'd2,
  parameter int                  PULSE_LANE = 6,
  parameter logic [SAMPLE_W-1:0] IDLE_CODE  = 16'h0000,
  parameter int                  FIFO_DEPTH = 4
)(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               gpio_in,
  input  logic [VAL_W-1:0]          val_in,
  input  logic                      val_valid,
  output logic                      val_ready,
  input  logic                      dac_output_run,
  output logic [LANES*SAMPLE_W-1:0] m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      fifo_overflow
);

  localparam int          AW  = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] ONE = 1;

  logic        wr_pulse;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;

  gpio_write_decoder u_dec (
    .clk      (clk),
    .rst      (rst),
    .gpio_in  (gpio_in),
    .wr_pulse (wr_pulse),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  byte_st_e            bst;
  logic [7:0]          ptr;
  logic [7:0]          hi;
  logic                lut_we;
  logic [SAMPLE_W-1:0] idle;

  assign lut_we = wr_pulse
                & (wr_addr == ADDR_DATA)
                & (bst == S_LO);

`ifdef DAC_IDLE_REG_EN
  logic [SAMPLE_W-1:0] idle_q;
  logic [7:0]          idle_hi;
  logic                idle_lo;
  assign idle = idle_q;
`else
  assign idle = IDLE_CODE;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bst <= S_HI;
      ptr <= '0;
      hi  <= '0;
`ifdef DAC_IDLE_REG_EN
      idle_q  <= IDLE_CODE;
      idle_hi <= '0;
      idle_lo <= 1'b0;
`endif
    end else if (wr_pulse) begin
      unique case (1'b1)
        (wr_addr == ADDR_PTR): begin
          ptr <= wr_data;
          bst <= S_HI;
`ifdef DAC_IDLE_REG_EN
          idle_lo <= 1'b0;
`endif
        end
        (wr_addr == ADDR_DATA): begin
          if (bst == S_HI) begin
            hi  <= wr_data;
            bst <= S_LO;
          end else begin
            ptr <= ptr + 8'd1;
            bst <= S_HI;
          end
        end
        (wr_addr == ADDR_IDLE): begin
`ifdef DAC_IDLE_REG_EN
          if (!idle_lo) begin
            idle_hi <= wr_data;
            idle_lo <= 1'b1;
          end else begin
            idle_q  <= {idle_hi, wr_data};
            idle_lo <= 1'b0;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  logic [VAL_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  out_st_e          ost;

  assign full  = (wptr[AW] != rptr[AW])
               & (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = (wptr == rptr);

  assign val_ready     = (ost == ST_STREAM) & ~full;
  assign m_axis_tvalid = (ost == ST_STREAM);
  assign push = val_valid & val_ready;
  assign pop  = (ost == ST_STREAM) & dac_output_run
              & ~empty & m_axis_tready;

  logic [SAMPLE_W-1:0] lut [256];
  // lut_q doubles as the skid register: it only reloads on pop,
  // and pop needs tready, so a stalled result simply waits here.
  logic [SAMPLE_W-1:0] lut_q;
  logic                rd_v;

  always_ff @(posedge clk) begin
    if (lut_we)
      lut[ptr] <= {hi, wr_data};
    if (pop)
      lut_q <= lut[fifo_mem[rptr[AW-1:0]]];
    if (push)
      fifo_mem[wptr[AW-1:0]] <= val_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ost           <= ST_RESET;
      wptr          <= '0;
      rptr          <= '0;
      rd_v          <= 1'b0;
      fifo_overflow <= 1'b0;
      m_axis_tdata  <= {LANES{IDLE_CODE}};
    end else begin
      ost <= ST_STREAM;
      if (push)
        wptr <= wptr + ONE;
      if (pop)
        rptr <= rptr + ONE;
      if (val_valid && full)
        fifo_overflow <= 1'b1;
      if (m_axis_tready) begin
        rd_v         <= pop;
        m_axis_tdata <= build_word(idle, lut_q,
                                   rd_v, PULSE_LANE);
      end
    end
  end

endmodule
